// File: rtl/dma_mem_responder_if.sv
// ---------------------------------------------------------------------------
// dma_mem_responder_if
//
// Purpose:
//   Bundles the three channels between the DMA load/store engine and the
//   memory-side responder: the command channel, the store (write-data)
//   channel and the load (read-data) channel, plus the completion pulses.
//
// Signal summary:
//   cmd_valid / cmd_ready            command handshake
//   cmd_addr  [ADDR_WIDTH]           burst base word address
//   cmd_size  [SIZE_WIDTH]           number of beats in the burst
//   cmd_mode  [MODE_WIDTH]           0001 = load, 0010 = store
//   wr_valid / wr_ready / wr_data    store beat channel (engine -> memory)
//   rd_valid / rd_ready / rd_data    load beat channel (memory -> engine)
//   rd_last                          marks the final load beat
//   done                             one-cycle completion pulse
//   err                              one-cycle pulse with done on a reject
//
// Modports:
//   master - the DMA engine side (drives commands and store data)
//   slave  - the responder side (drives ready signals and load data)
// ---------------------------------------------------------------------------
interface dma_mem_responder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_WIDTH = 8,
  parameter int MODE_WIDTH = 4
);

  // Command channel
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [SIZE_WIDTH-1:0] cmd_size;
  logic [MODE_WIDTH-1:0] cmd_mode;

  // Store data channel
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;

  // Load data channel
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;

  // Completion
  logic                  done;
  logic                  err;

  // The DMA engine issues commands, supplies store data and consumes loads.
  modport master (
    output cmd_valid, cmd_addr, cmd_size, cmd_mode,
    output wr_valid, wr_data,
    output rd_ready,
    input  cmd_ready, wr_ready,
    input  rd_valid, rd_data, rd_last,
    input  done, err
  );

  // The responder accepts commands, absorbs store data and produces loads.
  modport slave (
    input  cmd_valid, cmd_addr, cmd_size, cmd_mode,
    input  wr_valid, wr_data,
    input  rd_ready,
    output cmd_ready, wr_ready,
    output rd_valid, rd_data, rd_last,
    output done, err
  );

endinterface

// File: rtl/dma_mem_responder.sv
// ---------------------------------------------------------------------------
// dma_mem_responder
//
// Purpose:
//   Memory-side responder for the DMA load/store engine. Accepts one burst
//   command at a time and serves it against an internal word-addressed
//   memory of 2^ADDR_WIDTH words. Loads stream words out on the read-data
//   channel, stores absorb words from the write-data channel. Every command
//   finishes with a one-cycle done pulse; rejected commands (size 0 or an
//   unknown mode) also pulse err and leave memory untouched.
//
// Ports:
//   clk    - single clock, everything on the rising edge
//   rst_n  - asynchronous active-low reset (memory contents are not reset)
//   bus    - dma_mem_responder_if.slave: command, store and load channels
//
// Every output on the bus is a register, so nothing on the outputs depends
// combinationally on any input.
// ---------------------------------------------------------------------------
module dma_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_WIDTH = 8,
  parameter int MODE_WIDTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  dma_mem_responder_if.slave bus
);

  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

  localparam logic [MODE_WIDTH-1:0] MODE_LOAD  = MODE_WIDTH'(1);
  localparam logic [MODE_WIDTH-1:0] MODE_STORE = MODE_WIDTH'(2);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STORE,
    DONE
  } state_t;

  // -------------------------------------------------------------------------
  // State, burst bookkeeping and registered outputs
  // -------------------------------------------------------------------------
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_curAddr;
  logic [SIZE_WIDTH-1:0] r_beat;
  logic [SIZE_WIDTH-1:0] r_size;

  logic                  r_cmdReady;
  logic                  r_wrReady;
  logic                  r_rdValid;
  logic                  r_rdLast;
  logic [DATA_WIDTH-1:0] r_rdData;
  logic                  r_done;
  logic                  r_err;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // -------------------------------------------------------------------------
  // Decoded helpers
  // -------------------------------------------------------------------------
  logic                  w_cmdAccept;
  logic                  w_sizeNonZero;
  logic                  w_cmdIsLoad;
  logic                  w_cmdIsStore;
  logic                  w_cmdSingleBeat;
  logic                  w_rdFire;
  logic                  w_wrFire;
  logic [ADDR_WIDTH-1:0] w_nextAddr;
  logic [SIZE_WIDTH-1:0] w_nextBeat;
  logic [SIZE_WIDTH-1:0] w_lastBeatIdx;
  logic                  w_atLastBeat;
  logic                  w_nextIsLast;
  logic [ADDR_WIDTH-1:0] w_rdAddr;
  logic [DATA_WIDTH-1:0] w_rdWord;

  // cmd_ready is only ever high in IDLE, so it doubles as the IDLE qualifier.
  assign w_cmdAccept     = bus.cmd_valid && r_cmdReady;
  assign w_sizeNonZero   = (bus.cmd_size != '0);
  assign w_cmdIsLoad     = (bus.cmd_mode == MODE_LOAD)  && w_sizeNonZero;
  assign w_cmdIsStore    = (bus.cmd_mode == MODE_STORE) && w_sizeNonZero;
  assign w_cmdSingleBeat = (bus.cmd_size == SIZE_WIDTH'(1));

  // rd_valid is only high in LOAD and wr_ready only in STORE, which makes the
  // handshakes ignore the other channel's inputs outside their own state.
  assign w_rdFire = r_rdValid && bus.rd_ready;
  assign w_wrFire = r_wrReady && bus.wr_valid;

  // Address arithmetic wraps naturally at ADDR_WIDTH bits.
  assign w_nextAddr = r_curAddr + ADDR_WIDTH'(1);
  assign w_nextBeat = r_beat + SIZE_WIDTH'(1);

  // Beat comparisons are done in SIZE_WIDTH so size-1 never needs a sign.
  assign w_lastBeatIdx = r_size - SIZE_WIDTH'(1);
  assign w_atLastBeat  = (r_beat == w_lastBeatIdx);
  assign w_nextIsLast  = (w_nextBeat == w_lastBeatIdx);

  // A single read port serves both the first beat (straight from the command
  // address while idle) and every following beat (the next burst address).
  assign w_rdAddr = r_cmdReady ? bus.cmd_addr : w_nextAddr;
  assign w_rdWord = r_mem[w_rdAddr];

  // -------------------------------------------------------------------------
  // Memory write port. Kept out of the reset domain so that a reset in the
  // middle of a store leaves already-written words in place; wr_ready drops
  // asynchronously with reset, so no stray write lands afterwards.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wrFire) begin
      r_mem[r_curAddr] <= bus.wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Command FSM. All bus outputs are registered here and set up one edge
  // ahead of the state they belong to, so each output is a clean flop.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_curAddr  <= '0;
      r_beat     <= '0;
      r_size     <= '0;
      r_cmdReady <= 1'b1;
      r_wrReady  <= 1'b0;
      r_rdValid  <= 1'b0;
      r_rdLast   <= 1'b0;
      r_rdData   <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_cmdAccept) begin
            r_curAddr  <= bus.cmd_addr;
            r_beat     <= '0;
            r_size     <= bus.cmd_size;
            r_cmdReady <= 1'b0;
            if (w_cmdIsLoad) begin
              // First word is fetched on the accepting edge so rd_valid
              // comes up with valid data one cycle later.
              r_state   <= LOAD;
              r_rdValid <= 1'b1;
              r_rdData  <= w_rdWord;
              r_rdLast  <= w_cmdSingleBeat;
            end else if (w_cmdIsStore) begin
              r_state   <= STORE;
              r_wrReady <= 1'b1;
            end else begin
              // Rejected: go straight to completion with err raised.
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end

        LOAD: begin
          // Without a handshake nothing changes, so rd_data/rd_last hold.
          if (w_rdFire) begin
            if (r_rdLast) begin
              r_state   <= DONE;
              r_rdValid <= 1'b0;
              r_rdLast  <= 1'b0;
              r_done    <= 1'b1;
              r_err     <= 1'b0;
            end else begin
              r_curAddr <= w_nextAddr;
              r_beat    <= w_nextBeat;
              r_rdData  <= w_rdWord;
              r_rdLast  <= w_nextIsLast;
            end
          end
        end

        STORE: begin
          if (w_wrFire) begin
            r_curAddr <= w_nextAddr;
            r_beat    <= w_nextBeat;
            if (w_atLastBeat) begin
              r_state   <= DONE;
              r_wrReady <= 1'b0;
              r_done    <= 1'b1;
              r_err     <= 1'b0;
            end
          end
        end

        DONE: begin
          // Completion lasts exactly one cycle regardless of inputs.
          r_state    <= IDLE;
          r_done     <= 1'b0;
          r_err      <= 1'b0;
          r_cmdReady <= 1'b1;
        end

        default: begin
          r_state    <= IDLE;
          r_cmdReady <= 1'b1;
          r_wrReady  <= 1'b0;
          r_rdValid  <= 1'b0;
          r_rdLast   <= 1'b0;
          r_done     <= 1'b0;
          r_err      <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Drive the bus straight from the output registers.
  // -------------------------------------------------------------------------
  assign bus.cmd_ready = r_cmdReady;
  assign bus.wr_ready  = r_wrReady;
  assign bus.rd_valid  = r_rdValid;
  assign bus.rd_last   = r_rdLast;
  assign bus.rd_data   = r_rdData;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: doc/dma_mem_responder.md
# dma_mem_responder

Memory-side responder for the DMA load/store engine. It accepts one burst command at a time (base address, beat count, mode) and serves it against an internal word-addressed memory. A load streams words out on a read-data channel; a store absorbs words from a write-data channel. It sits between the DMA engine and the data memory and completes each command with a one-cycle `done` pulse.

## Interface
- `ADDR_WIDTH`, default 8: word address width; memory depth is 2^ADDR_WIDTH words.
- `DATA_WIDTH`, default 32: data word width.
- `SIZE_WIDTH`, default 8: beat-count width; maximum burst is 2^SIZE_WIDTH-1 beats.
- `MODE_WIDTH`, default 4: mode field width; 4'b0001 = load, 4'b0010 = store.

- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: responder can accept a command; high only in IDLE.
- `cmd_addr` input ADDR_WIDTH: burst base word address.
- `cmd_size` input SIZE_WIDTH: number of beats.
- `cmd_mode` input MODE_WIDTH: operation mode.
- `wr_valid` input 1: store data beat present.
- `wr_ready` output 1: responder accepts a store beat; high only in STORE.
- `wr_data` input DATA_WIDTH: store data.
- `rd_valid` output 1: load data beat present.
- `rd_ready` input 1: consumer accepts the load beat.
- `rd_data` output DATA_WIDTH: load data.
- `rd_last` output 1: marks the final load beat.
- `done` output 1: one-cycle pulse when a command completes.
- `err` output 1: one-cycle pulse coincident with `done` for a rejected command.

## Operation
- FSM states: IDLE, LOAD, STORE, DONE.
- IDLE: `cmd_ready`=1. A command is accepted on `cmd_valid && cmd_ready`, which latches `cur_addr`=`cmd_addr`, `beat`=0, and `size`.
  - Mode 0001 with size≠0: go to LOAD; `rd_data`<=mem[cmd_addr] in the same edge.
  - Mode 0010 with size≠0: go to STORE.
  - size=0 or any other mode: go to DONE with the error flag set. Memory is untouched.
- LOAD: `rd_valid`=1; `rd_last`=(beat==size-1), computed in SIZE_WIDTH.
  - On a handshake that is not the last beat: `cur_addr`+1, `beat`+1, `rd_data`<=mem[cur_addr+1].
  - On the last handshake: go to DONE.
  - `rd_data` and `rd_last` hold stable while `rd_valid && !rd_ready`.
- STORE: `wr_ready`=1.
  - Each `wr_valid` handshake writes mem[cur_addr]<=wr_data, then `cur_addr`+1 and `beat`+1.
  - After the handshake with beat==size-1: go to DONE.
- DONE: `done`=1 and `err`=error flag for exactly one cycle, then unconditionally go to IDLE. The error flag clears.
- Address arithmetic is ADDR_WIDTH-bit modulo: 2^ADDR_WIDTH-1 wraps to 0.
- A store followed by a load of the same address returns the stored word. There is no read-during-write hazard, because only one command is active at a time.
- Memory contents are not reset.

## Timing
- Reset (asynchronous assert, synchronous release) values:
  - State IDLE.
  - `cmd_ready`=1.
  - `wr_ready`=0, `rd_valid`=0, `rd_last`=0, `rd_data`=0, `done`=0, `err`=0.
  - Internal counters 0.
- Reset mid-burst aborts the command with no `done`. Words already stored remain in memory.
- Load latency: command accepted at edge T puts first `rd_valid` high after T with data mem[base]. With `rd_ready` held high, one beat is transferred per cycle.
- Store throughput: one beat per cycle with `wr_valid` held high.
- `done` is asserted the cycle after the final beat handshake, or the cycle after accepting a rejected command.
- `cmd_ready` returns high the cycle after `done`. The minimum command-to-command spacing is therefore size+2 cycles.
- `wr_valid` is ignored outside STORE. `rd_ready` is ignored outside LOAD. `cmd_valid` is ignored outside IDLE.
- All outputs are registered or decoded from state only; none depend combinationally on inputs.

## Test plan
- Store 4 beats at 0x10 with data 0xA0..0xA3, then load 4 beats at 0x10 -> `rd_data` is 0xA0,0xA1,0xA2,0xA3 on consecutive cycles; `rd_last` is high only on 0xA3; `done` pulses once per command with `err`=0.
- Load 3 beats with `rd_ready` toggling 1,0,0,1,1 -> each word is held stable while stalled; exactly 3 handshakes occur; `done` asserts the cycle after the third.
- Wrap: store 4 beats at 0xFE with 0x1..0x4, then load 0xFE,0x00 singly -> 0x1 and 0x3; mem[0xFF]=0x2 and mem[0x01]=0x4.
- Size 0 store, then mode 4'b0100 with size 2 -> each is accepted, `done`=`err`=1 for one cycle, `wr_ready` never goes high, and a follow-up load shows memory unchanged.
- Assert `rst_n`=0 after 2 of 5 store beats -> all outputs take their reset values asynchronously with no `done`; after release, a load of the first 2 addresses returns the 2 written words.
- Back-to-back commands with `cmd_valid` held high -> the second command is accepted exactly one cycle after the first `done`.
